// File: rtl/braile_pkg.sv
// braile_pkg: shared braille cell type, dot count and debouncer state encoding
package braile_pkg;
  localparam int DOT_COUNT = 6;
  typedef logic [DOT_COUNT-1:0] braile_cell_t;
  typedef enum logic [1:0] {
    DB_IDLE,
    DB_PRESS_WAIT,
    DB_PRESSED,
    DB_RELEASE_WAIT
  } db_state_t;
endpackage

// File: rtl/braile_debounce.sv
// braile_debounce: 2-flop synchronizer plus debounce FSM emitting one press pulse per confirmed press
module braile_debounce
  import braile_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw,
  output logic press
);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic [1:0] sync_q, sync_d;
  db_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic press_q, press_d;
  logic key, done;
  assign key   = sync_q[1];
  assign done  = cnt_q == CNT_LAST;
  assign press = press_q;
  // state register; synchronizer resets to 1 so the key reads as released
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b11;
      state_q <= DB_IDLE;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end
  // next state: both wait states count stable cycles from zero
  always_comb begin
    sync_d  = {sync_q[0], key_raw};
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    case (state_q)
      DB_IDLE: begin
        cnt_d   = '0;
        state_d = key ? DB_IDLE : DB_PRESS_WAIT;
      end
      DB_PRESS_WAIT:   state_d = key ? DB_IDLE : (done ? DB_PRESSED : DB_PRESS_WAIT);
      DB_PRESSED: begin
        cnt_d   = '0;
        state_d = key ? DB_RELEASE_WAIT : DB_PRESSED;
      end
      DB_RELEASE_WAIT: state_d = !key ? DB_PRESSED : (done ? DB_IDLE : DB_RELEASE_WAIT);
      default:         state_d = DB_IDLE;
    endcase
  end
  // output: pulse only on the confirmed PRESS_WAIT -> PRESSED transition
  always_comb begin
    press_d = (state_q == DB_PRESS_WAIT) && !key && done;
  end
endmodule

// File: rtl/braile_cell_entry.sv
// braile_cell_entry: debounced ENTER/CLEAR, switch capture into a FWFT FIFO with valid/ready output; BRAILE_ECHO_EN adds echo_leds
module braile_cell_entry
  import braile_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                            CLOCK_50,
  input  logic                            RESET_N,
  input  braile_cell_t                    SW,
  input  logic                            KEY_ENTER,
  input  logic                            KEY_CLEAR,
  output braile_cell_t                    cell_data,
  output logic                            cell_valid,
  input  logic                            cell_ready,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
  output logic                            overflow
`ifdef BRAILE_ECHO_EN
  ,
  output logic [7:0]                      echo_leds
`endif
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CW    = PTR_W + 1;
  braile_cell_t sw_meta_q, sw_meta_d, sw_sync_q, sw_sync_d;
  braile_cell_t mem_q [FIFO_DEPTH];
  braile_cell_t last_q, last_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic overflow_q, overflow_d;
  logic enter_p, clear_p, full, pop, push, wr_en;
  braile_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_enter (
    .clk(CLOCK_50), .rst_n(RESET_N), .key_raw(KEY_ENTER), .press(enter_p)
  );
  braile_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_clear (
    .clk(CLOCK_50), .rst_n(RESET_N), .key_raw(KEY_CLEAR), .press(clear_p)
  );
  assign cell_valid = count_q != '0;
  assign cell_data  = cell_valid ? mem_q[rd_ptr_q] : last_q;
  assign fifo_count = count_q;
  assign overflow   = overflow_q;
  // control state; reset discards every buffered cell at once
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      last_q     <= '0;
    end else begin
      sw_meta_q  <= sw_meta_d;
      sw_sync_q  <= sw_sync_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      last_q     <= last_d;
    end
  end
  // storage array needs no reset: count gates every read
  always_ff @(posedge CLOCK_50) begin
    if (wr_en) mem_q[wr_ptr_q] <= sw_sync_q;
  end
  // FIFO next state; pop needs valid so an empty FIFO never bypasses, CLEAR overrides push and pop
  always_comb begin
    sw_meta_d  = SW;
    sw_sync_d  = sw_meta_q;
    full       = count_q == CW'(FIFO_DEPTH);
    pop        = cell_valid && cell_ready;
    push       = enter_p && (!full || pop);
    wr_en      = push && !clear_p;
    wr_ptr_d   = clear_p ? '0 : wr_ptr_q + PTR_W'(push);
    rd_ptr_d   = clear_p ? '0 : rd_ptr_q + PTR_W'(pop);
    count_d    = clear_p ? '0 : count_q + CW'(push) - CW'(pop);
    overflow_d = clear_p ? 1'b0 : overflow_q | (enter_p && full && !pop);
    last_d     = cell_valid ? mem_q[rd_ptr_q] : last_q;
  end
`ifdef BRAILE_ECHO_EN
  logic [7:0] echo_q, echo_d;
  assign echo_leds = echo_q;
  // live switch/status mirror for the LEDs
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) echo_q <= '0;
    else echo_q <= echo_d;
  end
  // echo source: overflow, valid and synchronized switches
  always_comb begin
    echo_d = {overflow_q, cell_valid, sw_sync_q};
  end
`endif
endmodule
